// File: rtl/regfile_mem_datapath.sv
// Multi-cycle datapath: 32x WORDSIZE register file, 32-entry data memory and an add/sub unit,
// sequenced by an IDLE -> READ -> EXEC -> WB control FSM, one operation per start pulse.
module regfile_mem_datapath #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned IMMSIZE  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [6:0]          op_code,
    input  logic [4:0]          rs1,
    input  logic [4:0]          rs2,
    input  logic [4:0]          rd,
    input  logic [IMMSIZE-1:0]  rd_in,
    output logic [WORDSIZE-1:0] rs1_out,
    output logic [WORDSIZE-1:0] rs2_out,
    output logic [WORDSIZE-1:0] result,
    output logic                overflow,
    output logic                busy,
    output logic                done
);

    localparam int unsigned Depth = 32;

    typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_e;
    typedef enum logic [2:0] {OpNone, OpStore, OpAdd, OpSub, OpLi, OpLoad} op_e;

    state_e state_q, state_d;
    op_e    op_q;

    logic [4:0]          rs1_q, rs2_q, rd_q;
    logic [IMMSIZE-1:0]  imm_q;
    logic [WORDSIZE-1:0] a_q, b_q;
    logic [4:0]          store_addr_q;
    logic [WORDSIZE-1:0] result_q, result_d;
    logic                overflow_q, overflow_d;

    logic [WORDSIZE-1:0] regs [Depth];
    logic [WORDSIZE-1:0] mem  [Depth];

    logic                accept;
    logic                reg_we;
    logic                mem_we;
    logic [WORDSIZE-1:0] sum, diff;

    assign accept = start && (op_code >= 7'd1) && (op_code <= 7'd5);

    // ---------------------------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StRead;
            StRead: state_d = StExec;
            StExec: state_d = StWb;
            StWb:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StWb);

    // Request capture: the running operation is isolated from later port changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OpNone;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
            imm_q <= '0;
        end else if (state_q == StIdle && accept) begin
            op_q  <= op_e'(op_code[2:0]);
            rs1_q <= rs1;
            rs2_q <= rs2;
            rd_q  <= rd;
            imm_q <= rd_in;
        end
    end

    // Operand latch; only the low address bits of r[rd] matter for a store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            store_addr_q <= '0;
        end else if (state_q == StRead) begin
            a_q          <= regs[rs1_q];
            b_q          <= regs[rs2_q];
            store_addr_q <= regs[rd_q][4:0];
        end
    end

    // ---------------------------------------------------------------------------------------
    // Execute
    // ---------------------------------------------------------------------------------------
    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;

    always_comb begin
        result_d   = result_q;
        overflow_d = overflow_q;
        if (state_q == StExec) begin
            unique case (op_q)
                OpAdd: begin
                    result_d   = sum;
                    overflow_d = (a_q[WORDSIZE-1] == b_q[WORDSIZE-1]) &&
                                 (sum[WORDSIZE-1] != a_q[WORDSIZE-1]);
                end
                OpSub: begin
                    result_d   = diff;
                    overflow_d = (a_q[WORDSIZE-1] != b_q[WORDSIZE-1]) &&
                                 (diff[WORDSIZE-1] != a_q[WORDSIZE-1]);
                end
                OpLi:    result_d = WORDSIZE'(imm_q);
                OpLoad:  result_d = mem[a_q[4:0]];
                OpStore: result_d = a_q;
                default: result_d = result_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;

    // ---------------------------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------------------------
    assign mem_we = (state_q == StExec) && (op_q == OpStore);
    assign reg_we = (state_q == StWb) &&
                    ((op_q == OpAdd) || (op_q == OpSub) || (op_q == OpLi) || (op_q == OpLoad));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[store_addr_q] <= a_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[rd_q] <= result_q;
        end
    end

    assign rs1_out = regs[rs1];
    assign rs2_out = regs[rs2];

endmodule

// File: tb/tb_regfile_mem_datapath.sv
// Directed plus randomized bench for regfile_mem_datapath against an array-based reference
// model of the register file, memory and the add/sub/load/store rules.
module tb_regfile_mem_datapath;

    localparam int W = 64;
    localparam int I = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [6:0]    op_code = '0;
    logic [4:0]    rs1 = '0, rs2 = '0, rd = '0;
    logic [I-1:0]  rd_in = '0;
    logic [W-1:0]  rs1_out, rs2_out, result;
    logic          overflow, busy, done;

    regfile_mem_datapath #(.WORDSIZE(W), .IMMSIZE(I)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_code  (op_code),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .rd_in    (rd_in),
        .rs1_out  (rs1_out),
        .rs2_out  (rs2_out),
        .result   (result),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] m_regs [32];
    logic [W-1:0] m_mem  [32];
    logic [W-1:0] m_result;
    logic         m_ovf;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_mem[i]  = '0;
        end
        m_result = '0;
        m_ovf    = 1'b0;
    endtask

    // Reference semantics using whole-number arithmetic on the operand values.
    task automatic model_exec(input int op, input int a1, input int a2, input int ad,
                              input logic [I-1:0] imm);
        logic [W-1:0]   va, vb;
        logic signed [W:0] wide;
        va = m_regs[a1];
        vb = m_regs[a2];
        case (op)
            1: begin
                m_mem[m_regs[ad] % 32] = va;
                m_result = va;
            end
            2, 3: begin
                if (op == 2) wide = $signed({va[W-1], va}) + $signed({vb[W-1], vb});
                else         wide = $signed({va[W-1], va}) - $signed({vb[W-1], vb});
                m_result = wide[W-1:0];
                m_ovf    = (wide > $signed({1'b0, {(W-1){1'b1}}})) ||
                           (wide < -$signed({1'b0, 1'b1, {(W-1){1'b0}}}));
            end
            4: m_result = {{(W-I){1'b0}}, imm};
            5: m_result = m_mem[va % 32];
            default: ;
        endcase
        if (op >= 2 && op <= 5) m_regs[ad] = m_result;
    endtask

    task automatic scramble();
        op_code = 7'($urandom);
        rs1     = 5'($urandom);
        rs2     = 5'($urandom);
        rd      = 5'($urandom);
        rd_in   = $urandom;
    endtask

    // One operation, checked every cycle from accept to the return to IDLE.
    task automatic run_op(input int op, input int a1, input int a2, input int ad,
                          input logic [I-1:0] imm, input bit hold);
        int probe;
        @(negedge clk);
        op_code = 7'(op);
        rs1 = 5'(a1); rs2 = 5'(a2); rd = 5'(ad); rd_in = imm;
        start = 1'b1;
        @(posedge clk);
        #1;
        scramble();
        start = hold;
        @(negedge clk);
        check("read_busy", W'(busy), W'(1));
        check("read_done", W'(done), W'(0));
        @(negedge clk);
        check("exec_done", W'(done), W'(0));
        @(negedge clk);
        model_exec(op, a1, a2, ad, imm);
        check("wb_done", W'(done), W'(1));
        check("wb_result", result, m_result);
        check("wb_overflow", W'(overflow), W'(m_ovf));
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", W'(busy), W'(0));
        check("idle_done", W'(done), W'(0));
        probe = $urandom_range(0, 31);
        rs1 = 5'(ad);
        rs2 = 5'(probe);
        #1;
        check("rd_readback", rs1_out, m_regs[ad]);
        check("probe_readback", rs2_out, m_regs[probe]);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_result", result, '0);
        check("rst_overflow", W'(overflow), W'(0));
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            check("rst_reg", rs1_out, '0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // li / add
        run_op(4, 0, 0, 2, 32'd7, 1'b0);
        run_op(4, 0, 0, 3, 32'd5, 1'b0);
        run_op(2, 2, 3, 10, '0, 1'b0);
        check("add_12", result, 64'd12);

        // sub wrap
        run_op(4, 0, 0, 4, 32'd3, 1'b0);
        run_op(4, 0, 0, 5, 32'd5, 1'b0);
        run_op(3, 4, 5, 14, '0, 1'b0);
        check("sub_wrap", result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_novf", W'(overflow), W'(0));

        // Build 0x7FFF... by doubling plus one, then overflow into the sign bit.
        run_op(4, 0, 0, 6, 32'hFFFF_FFFF, 1'b0);
        run_op(4, 0, 0, 1, 32'd1, 1'b0);
        for (int k = 0; k < 31; k++) begin
            run_op(2, 6, 6, 6, '0, 1'b0);
            run_op(2, 6, 1, 6, '0, 1'b0);
        end
        check("max_pos", m_regs[6], 64'h7FFF_FFFF_FFFF_FFFF);
        run_op(2, 6, 1, 8, '0, 1'b0);
        check("ovf_result", result, 64'h8000_0000_0000_0000);
        check("ovf_flag", W'(overflow), W'(1));
        run_op(4, 0, 0, 11, 32'h55, 1'b0);
        check("ovf_sticky", W'(overflow), W'(1));

        // Store/load round trip with address wrap (37 -> 5).
        run_op(4, 0, 0, 4, 32'hABCD, 1'b0);
        run_op(4, 0, 0, 7, 32'd37, 1'b0);
        run_op(1, 4, 0, 7, '0, 1'b0);
        run_op(4, 0, 0, 1, 32'd5, 1'b0);
        run_op(5, 1, 0, 9, '0, 1'b0);
        check("load_back", result, 64'hABCD);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            check("regfile_state", rs1_out, m_regs[i]);
        end

        // Ignored op codes.
        foreach (m_mem[j]) if (j < 2) begin
            @(negedge clk);
            op_code = (j == 0) ? 7'd0 : 7'd9;
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check("ignored_busy", W'(busy), W'(0));
                check("ignored_done", W'(done), W'(0));
            end
        end

        // start held while busy: exactly one operation.
        run_op(2, 2, 3, 12, '0, 1'b1);
        @(negedge clk);
        check("no_requeue_busy", W'(busy), W'(0));

        // Random operations.
        for (int n = 0; n < 60; n++) begin
            run_op($urandom_range(1, 5), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom, 1'b0);
        end

        // Reset during EXEC of an add.
        @(negedge clk);
        op_code = 7'd2; rs1 = 5'd2; rs2 = 5'd3; rd = 5'd20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_done", W'(done), W'(0));
        check("midrst_result", result, '0);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            check("midrst_reg", rs1_out, '0);
        end
        repeat (3) @(negedge clk);
        check("midrst_no_write", W'(busy), W'(0));
        rst_n = 1'b1;
        run_op(4, 0, 0, 20, 32'h1234, 1'b0);
        run_op(2, 20, 20, 21, '0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach the end, got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule
